// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one external combinational ALU between NUM_REQ requesters.
// Each operation runs IDLE (accept) -> EXEC (ALU evaluates) -> RESP (hold result until taken).
module alu_rr_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned IDW     = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*DW-1:0]  req_a_i,
    input  logic [NUM_REQ*DW-1:0]  req_b_i,
    input  logic [NUM_REQ*3-1:0]   req_op_i,
    output logic [NUM_REQ-1:0]     resp_valid_o,
    input  logic [NUM_REQ-1:0]     resp_ready_i,
    output logic [DW:0]            resp_data_o,
    output logic [IDW-1:0]         grant_id_o,
    output logic                   busy_o,
    output logic [DW-1:0]          alu_a_o,
    output logic [DW-1:0]          alu_b_o,
    output logic [2:0]             alu_ctrl_o,
    input  logic [DW:0]            alu_c_i
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       grant_q;
    logic [DW-1:0]        a_q, b_q;
    logic [2:0]           op_q;
    logic [DW:0]          res_q;

    logic                 win_found;
    logic [IDW-1:0]       win_idx;
    logic [NUM_REQ-1:0]   win_oh;
    logic [NUM_REQ-1:0]   grant_oh;
    logic                 resp_ack;

    // Search ptr+1, ptr+2, ... wrapping at NUM_REQ; the sum is one bit wider so it cannot overflow.
    always_comb begin
        logic [IDW:0]       cand;
        logic [NUM_REQ-1:0] shifted;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        shifted   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            shifted = req_valid_i >> cand;
            if (!win_found && shifted[0]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    assign win_oh   = NUM_REQ'(1) << win_idx;
    assign grant_oh = NUM_REQ'(1) << grant_q;
    assign resp_ack = |(resp_ready_i & grant_oh);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (win_found) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (resp_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        busy_o       = (state_q != StIdle);
        if (state_q == StIdle && win_found) begin
            req_ready_o = win_oh;
        end
        if (state_q == StResp) begin
            resp_valid_o = grant_oh;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q   <= IDW'(NUM_REQ - 1);
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        grant_q <= win_idx;
                        a_q     <= DW'(req_a_i >> (32'(win_idx) * DW));
                        b_q     <= DW'(req_b_i >> (32'(win_idx) * DW));
                        op_q    <= 3'(req_op_i >> (32'(win_idx) * 3));
                    end
                end
                StExec: res_q <= alu_c_i;
                StResp: if (resp_ack) ptr_q <= grant_q;
                default: ;
            endcase
        end
    end

    // ALU inputs come straight from registers so they are stable for the whole EXEC cycle.
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_ctrl_o  = op_q;
    assign resp_data_o = res_q;
    assign grant_id_o  = grant_q;

endmodule
